// File: rtl/axi_pkg.sv
// Shared AXI definitions used by the AXI slave responder and the AXI master bridge.
package axi_pkg;

    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;
    localparam logic [AXI_BURST_W-1:0] BURST_RSVD  = 2'b11;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

    // Responder FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_MEM  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_RESP = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_WR_RESP = 3'd5
    } axi_state_e;

    // Burst shape latched from an AW/AR handshake
    typedef struct packed {
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } ax_ctrl_t;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Next-beat address calculation for FIXED/INCR/WRAP bursts plus illegal-burst detection.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_SIZE = 3
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  ax_ctrl_t          ctrl_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              err_o
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_bytes;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr_addr;

    // Address step, wrap window and the advanced address for every burst type
    always_comb begin
        step        = ADDR_W'(1) << ctrl_i.size;
        wrap_bytes  = ADDR_W'({1'b0, ctrl_i.len} + 9'd1) << ctrl_i.size;
        wrap_mask   = wrap_bytes - ADDR_W'(1);
        incr_addr   = addr_i + step;
        next_addr_o = addr_i;
        case (ctrl_i.burst)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = incr_addr;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_o = addr_i;
        endcase
    end

    // Reserved burst, oversize beat or illegal WRAP length
    always_comb begin
        err_o = (ctrl_i.burst == BURST_RSVD)
             || (ctrl_i.size > AXI_SIZE_W'(MAX_SIZE))
             || ((ctrl_i.burst == BURST_WRAP) && !wrap_len_ok(ctrl_i.len));
    end

endmodule

// File: rtl/axi2mem.sv
// AXI4 slave responder: serves one read or write burst at a time from a
// single-port synchronous memory, one memory access per beat.
module axi2mem
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // write address
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    // write data
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    // write response
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    // read address
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_W-1:0]       arid,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    // read data
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    // memory port
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned LANE_LSB = $clog2(STRB_W);

    axi_state_e              state_q, state_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    ax_ctrl_t                ctrl_q, ctrl_d;
    logic [AXI_LEN_W-1:0]    cnt_q, cnt_d;
    logic                    werr_q, werr_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [ID_W-1:0]         rid_q, rid_d;
    logic [AXI_RESP_W-1:0]   rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;
    logic [ID_W-1:0]         bid_q, bid_d;
    logic [AXI_RESP_W-1:0]   bresp_q, bresp_d;

    logic [ADDR_W-1:0]       addr_next;
    logic                    xfer_err;
    logic                    last_beat;
    logic                    wlast_bad;

    axi_addr_gen #(
        .ADDR_W   (ADDR_W),
        .MAX_SIZE (LANE_LSB)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .ctrl_i      (ctrl_q),
        .next_addr_o (addr_next),
        .err_o       (xfer_err)
    );

    assign last_beat = (cnt_q == ctrl_q.len);
    assign wlast_bad = (wlast != last_beat);

    // Memory address is beat-aligned; write payload passes straight through
    assign mem_addr  = {addr_q[ADDR_W-1:LANE_LSB], {LANE_LSB{1'b0}}};
    assign mem_wdata = wdata;
    assign mem_wstrb = wstrb;

    // Response payloads come from holding registers so they stay put under back-pressure
    assign rdata = rdata_q;
    assign rid   = rid_q;
    assign rresp = rresp_q;
    assign rlast = rlast_q;
    assign bid   = bid_q;
    assign bresp = bresp_q;

    // State and holding registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
            werr_q  <= 1'b0;
            rdata_q <= '0;
            rid_q   <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
            bid_q   <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            werr_q  <= werr_d;
            rdata_q <= rdata_d;
            rid_q   <= rid_d;
            rresp_q <= rresp_d;
            rlast_q <= rlast_d;
            bid_q   <= bid_d;
            bresp_q <= bresp_d;
        end
    end

    // Next-state, handshake and memory-strobe logic
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        werr_d  = werr_q;
        rdata_d = rdata_q;
        rid_d   = rid_q;
        rresp_d = rresp_q;
        rlast_d = rlast_q;
        bid_d   = bid_q;
        bresp_d = bresp_q;
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        rvalid  = 1'b0;
        bvalid  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (awvalid) begin
                    // writes win when both channels present an address
                    awready      = 1'b1;
                    id_d         = awid;
                    addr_d       = awaddr;
                    ctrl_d.len   = awlen;
                    ctrl_d.size  = awsize;
                    ctrl_d.burst = awburst;
                    cnt_d        = '0;
                    werr_d       = 1'b0;
                    state_d      = ST_WR_DATA;
                end else if (arvalid) begin
                    arready      = 1'b1;
                    id_d         = arid;
                    addr_d       = araddr;
                    ctrl_d.len   = arlen;
                    ctrl_d.size  = arsize;
                    ctrl_d.burst = arburst;
                    cnt_d        = '0;
                    state_d      = ST_RD_MEM;
                end
            end

            ST_RD_MEM: begin
                mem_req = !xfer_err;
                state_d = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                rdata_d = xfer_err ? '0 : mem_rdata;
                rid_d   = id_q;
                rresp_d = xfer_err ? RESP_SLVERR : RESP_OKAY;
                rlast_d = last_beat;
                state_d = ST_RD_RESP;
            end

            ST_RD_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    rlast_d = 1'b0;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_next;
                        cnt_d   = cnt_q + AXI_LEN_W'(1);
                        state_d = ST_RD_MEM;
                    end
                end
            end

            ST_WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_req = !xfer_err;
                    mem_we  = !xfer_err;
                    if (wlast_bad) begin
                        werr_d = 1'b1;
                    end
                    if (last_beat) begin
                        bid_d   = id_q;
                        bresp_d = (xfer_err || werr_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                        state_d = ST_WR_RESP;
                    end else begin
                        addr_d = addr_next;
                        cnt_d  = cnt_q + AXI_LEN_W'(1);
                    end
                end
            end

            ST_WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/axi2mem.md
# axi2mem

AXI4 slave-side responder that accepts burst reads and writes on the `io_slave_*` port group and serves them beat by beat from a single-port synchronous memory. It is the responder counterpart of `mem2axi`, which initiates AXI bursts from the cache/SRAM bus. Its uses are:
- a DMA/peripheral target inside the core;
- a behavioural AXI memory for NPC simulation.

## Interface
Parameters:
- `ADDR_W`, 32, AXI and memory byte-address width
- `DATA_W`, 64, AXI data and memory word width (8-byte lanes)
- `ID_W`, 4, AXI ID width

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `awvalid/awready`  in/out  1/1  write-address handshake
- `awid`, `awaddr`, `awlen`, `awsize`, `awburst`  in  ID_W/ADDR_W/8/3/2  write-address fields
- `wvalid/wready`  in/out  1/1  write-data handshake
- `wdata`, `wstrb`, `wlast`  in  DATA_W/8/1  write-data fields
- `bvalid/bready`  out/in  1/1  write-response handshake
- `bid`, `bresp`  out  ID_W/2  write-response fields
- `arvalid/arready`  in/out  1/1  read-address handshake
- `arid`, `araddr`, `arlen`, `arsize`, `arburst`  in  ID_W/ADDR_W/8/3/2  read-address fields
- `rvalid/rready`  out/in  1/1  read-data handshake
- `rid`, `rdata`, `rresp`, `rlast`  out  ID_W/DATA_W/2/1  read-data fields
- `mem_req`  out  1  memory access strobe, one cycle per beat
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  ADDR_W  byte address of the beat, low 3 bits forced to 0
- `mem_wdata`  out  DATA_W  write data
- `mem_wstrb`  out  8  byte enables
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after a read `mem_req`

## Operation
States: IDLE, RD_MEM, RD_WAIT, RD_RESP, WR_DATA, WR_RESP.

IDLE:
- Accept one address per transaction; no outstanding overlap.
- If `awvalid` and `arvalid` are both high, the write is taken first (fixed priority).
- `awready`/`arready` are high only in IDLE, for the selected channel.
- On acceptance, latch id, addr, len, size, burst; clear the beat counter; go to WR_DATA or RD_MEM.

Address sequencing:
- Address step is `1<<size`.
- FIXED (00): address held constant.
- INCR (01): address += step.
- WRAP (10): wrap boundary is `(len+1)<<size`. WRAP is legal only for len 1/3/7/15; other lengths are flagged as an error.
- Burst 11, or `size > 3`: the transaction is flagged as an error.

Error transactions:
- Issue no `mem_req`.
- Still run the full beat count.
- Every response carries SLVERR (2'b10); `rdata` = 0.

Read path:
- RD_MEM: pulse `mem_req` (`mem_we`=0) → RD_WAIT.
- RD_WAIT: register `mem_rdata` into the `rdata` holding register → RD_RESP.
- RD_RESP: `rvalid`=1. `rlast`=1 when beat counter == len.
- On `rready`:
  - if last beat → IDLE;
  - else advance the address, increment the counter → RD_MEM.

Write path:
- WR_DATA: `wready`=1. On `wvalid`, issue `mem_req` (`mem_we`=1) with `wdata`/`wstrb` in the same cycle, then advance address and counter.
- At beat == len → WR_RESP.
- If `wlast` does not match (beat == len), latch a protocol error. The transaction still ends at beat len, and `bresp` = SLVERR.
- WR_RESP: `bvalid`=1 with the latched `bid`/`bresp` until `bready` → IDLE.

Responses echo the latched ID. OKAY = 2'b00.

## Timing
- Reset values: all ready/valid outputs 0, `mem_req` 0, `bresp`/`rresp` 0, `rdata` 0, `rlast` 0, `bid`/`rid` 0; state IDLE.
- Reset asserted mid-burst aborts the burst next edge with no response. Upstream must be reset together with this block.
- Read beats take at least 3 cycles each (RD_MEM, RD_WAIT, RD_RESP):
  - first `rvalid` appears 3 cycles after the AR handshake edge;
  - back-to-back beats with `rready` held high arrive every 3 cycles.
- Write: one beat per cycle while `wvalid` is high. `bvalid` rises the cycle after the last W handshake.
- Output payloads (`rdata`, `rid`, `rresp`, `rlast`, `bid`, `bresp`) are stable while the corresponding valid is high and ready is low.
- `awready`/`arready` are driven combinationally from state and the valid inputs. No ready depends combinationally on a ready of the same channel.
- Beat counter is 8 bits, so `len` = 255 gives 256 beats with no overflow. The INCR address wraps modulo 2^ADDR_W.

## Structure
- Shared package `axi_pkg`: BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR, the state enum, and width constants reused with `mem2axi`.
- One sub-module, `axi_addr_gen`: combinational next-address calculation from (addr, size, len, burst), plus the error flag. It is reused by the read and write paths.

## Test plan
- INCR read, `araddr`=0x1000, len=3, size=3, memory preloaded i×0x11 → 4 beats of rdata 0x00, 0x11, 0x22, 0x33 from addrs 0x1000–0x1018, `rlast` only on beat 4, `rid` = `arid`, rresp 00.
- WRAP write, addr 0x1030, len=3, size=3 → mem addrs 0x1030, 0x1038, 0x1020, 0x1028; bresp 00.
- `awvalid` and `arvalid` in the same cycle → AW accepted first, AR accepted only after the B handshake.
- Write with len=1 and `wlast` on beat 1 → exactly 2 `mem_req`, bresp 10.
- `arsize`=4 → no `mem_req`, len+1 beats of rdata 0 with rresp 10.
- `rready` held low 5 cycles on beat 2, then reset mid-burst → outputs stable while held, all valids 0 and state IDLE the cycle after reset.
